// File: rtl/riscv_imem_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_imem_ctrl
// Instruction-memory controller and run sequencer for a single-cycle RISC-V
// core. Holds a DEPTH x 32 instruction store, fills it from a host
// valid/ready stream, serves the processor's fetch from pc_in and gates
// execution with cpu_en until EBREAK, a cycle limit or a host halt stops it.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   load_start          pulse: begin a program load (IDLE only)
//   run_start           pulse: begin execution (IDLE only, load_start wins)
//   halt_req            host stop request while running
//   done_ack            acknowledge completion, DONE -> IDLE
//   ld_valid/ld_data/ld_last/ld_ready   host load stream
//   pc_in               processor PC
//   instr_out           fetched instruction (NOP_WORD when not valid)
//   cpu_en              processor advance enable (high in RUN)
//   state               0=IDLE 1=LOAD 2=RUN 3=DONE
//   word_count          number of valid words in the store
//   cycle_count         RUN cycles elapsed (saturating)
//   done                high in DONE
//   overflow            sticky: load stream ran past DEPTH words
//   halt_reason         0=none 1=EBREAK 2=cycle limit 3=host halt
// -----------------------------------------------------------------------------
module riscv_imem_ctrl #(
    parameter int          DEPTH      = 64,
    parameter int          ADDR_W     = 6,
    parameter int          MAX_CYCLES = 0,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              halt_req,
    input  logic              done_ack,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       pc_in,
    output logic [31:0]       instr_out,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       cycle_count,
    output logic              done,
    output logic              overflow,
    output logic [1:0]        halt_reason
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0]     EBREAK_WORD = 32'h00100073;
    // Byte-address limit of the store, one bit wider so 4*DEPTH never wraps.
    localparam logic [32:0]     PC_LIMIT    = 33'(4 * DEPTH);
    localparam logic [ADDR_W:0] LAST_SLOT   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [32:0]     CYCLE_LIMIT = 33'(MAX_CYCLES);
    localparam logic [ADDR_W:0] WC_ONE      = (ADDR_W + 1)'(1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W:0]     word_count_r;
    logic [31:0]         cycle_count_r;
    logic                overflow_r;
    logic [1:0]          halt_reason_r;
    logic [31:0]         mem_r [DEPTH];

    logic [ADDR_W-1:0]   fetch_idx_s;
    logic                fetch_ok_s;
    logic [31:0]         instr_s;
    logic                xfer_s;
    logic                last_slot_s;
    logic                ebreak_s;
    logic                limit_s;

    // Saturating increment for the run-cycle counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFFFFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    assign fetch_idx_s = pc_in[ADDR_W+1:2];
    // Fetch is served from the store only for an aligned, in-range PC that
    // points at a word actually written by the last load.
    assign fetch_ok_s  = (state_r == ST_RUN) && (pc_in[1:0] == 2'b00) &&
                         ({1'b0, pc_in} < PC_LIMIT) &&
                         ({1'b0, fetch_idx_s} < word_count_r);
    assign xfer_s      = (state_r == ST_LOAD) && ld_valid;
    assign last_slot_s = (word_count_r == LAST_SLOT);
    assign ebreak_s    = (instr_s == EBREAK_WORD);
    assign limit_s     = (MAX_CYCLES != 0) &&
                         (({1'b0, cycle_count_r} + 33'd1) == CYCLE_LIMIT);

    // Instruction fetch mux: stored word or NOP.
    always_comb begin
        instr_s = NOP_WORD;
        if (fetch_ok_s) begin
            instr_s = mem_r[fetch_idx_s];
        end else begin
            instr_s = NOP_WORD;
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt_s = ST_LOAD;
                end else if (run_start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Leave on the final word or when the store is full.
                if (xfer_s && (ld_last || last_slot_s)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (halt_req || ebreak_s || limit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters and status flags, updated according to the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_r  <= '0;
            cycle_count_r <= 32'd0;
            overflow_r    <= 1'b0;
            halt_reason_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        word_count_r <= '0;
                        overflow_r   <= 1'b0;
                    end else if (run_start) begin
                        cycle_count_r <= 32'd0;
                        halt_reason_r <= 2'd0;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        word_count_r <= word_count_r + WC_ONE;
                        if (last_slot_s && !ld_last) begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The halting cycle is counted as well.
                    cycle_count_r <= sat_inc(cycle_count_r);
                    if (halt_req) begin
                        halt_reason_r <= 2'd3;
                    end else if (ebreak_s) begin
                        halt_reason_r <= 2'd1;
                    end else if (limit_s) begin
                        halt_reason_r <= 2'd2;
                    end
                end
                default: begin
                    word_count_r <= word_count_r;
                end
            endcase
        end
    end

    // Instruction store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            mem_r[word_count_r[ADDR_W-1:0]] <= ld_data;
        end
    end

    assign ld_ready    = (state_r == ST_LOAD);
    assign cpu_en      = (state_r == ST_RUN);
    assign done        = (state_r == ST_DONE);
    assign state       = state_r;
    assign instr_out   = instr_s;
    assign word_count  = word_count_r;
    assign cycle_count = cycle_count_r;
    assign overflow    = overflow_r;
    assign halt_reason = halt_reason_r;

endmodule

// File: tb/tb_riscv_imem_ctrl.sv
module tb_riscv_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        run_start = 1'b0;
    logic        halt_req = 1'b0;
    logic        done_ack = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic        ld_last = 1'b0;
    logic [31:0] pc_in = 32'd0;

    logic        ld_ready, cpu_en, done, overflow;
    logic [31:0] instr_out, cycle_count;
    logic [1:0]  state, halt_reason;
    logic [6:0]  word_count;

    logic        l_ld_ready, l_cpu_en, l_done, l_overflow;
    logic [31:0] l_instr_out, l_cycle_count;
    logic [1:0]  l_state, l_halt_reason;
    logic [6:0]  l_word_count;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] EBRK = 32'h00100073;

    logic [31:0] prog1 [7] = '{32'hABCDE2B7, 32'hBE51C337, 32'h190323B7,
                               32'h12328293, 32'h7A530313, 32'h90338393,
                               32'h00100073};
    logic [31:0] prog2 [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    riscv_imem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .run_start(run_start),
        .halt_req(halt_req), .done_ack(done_ack), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .pc_in(pc_in), .instr_out(instr_out), .cpu_en(cpu_en), .state(state),
        .word_count(word_count), .cycle_count(cycle_count), .done(done),
        .overflow(overflow), .halt_reason(halt_reason)
    );

    riscv_imem_ctrl #(.MAX_CYCLES(5)) dut_lim (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .run_start(run_start),
        .halt_req(halt_req), .done_ack(done_ack), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(l_ld_ready),
        .pc_in(pc_in), .instr_out(l_instr_out), .cpu_en(l_cpu_en), .state(l_state),
        .word_count(l_word_count), .cycle_count(l_cycle_count), .done(l_done),
        .overflow(l_overflow), .halt_reason(l_halt_reason)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_wc", {25'd0, word_count}, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_hr", {30'd0, halt_reason}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_instr", instr_out, NOP);
        rst_n = 1'b1;
        tick();

        // ---------------- test 1: load 7 words, run to EBREAK ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t1_load_state", {30'd0, state}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog1[i];
            ld_last  = (i == 6);
            #1;
            chk("t1_ready", {31'd0, ld_ready}, 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t1_idle", {30'd0, state}, 32'd0);
        chk("t1_wc", {25'd0, word_count}, 32'd7);
        chk("t1_instr_idle", instr_out, NOP);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("t1_run", {30'd0, state}, 32'd2);
        chk("t1_cpu_en", {31'd0, cpu_en}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            pc_in = 32'(4 * i);
            #1;
            chk($sformatf("t1_instr_pc%0d", 4 * i), instr_out, prog1[i]);
            if (i == 4) begin
                chk("t1_lim_still_run", {30'd0, l_state}, 32'd2);
            end
            tick();
        end
        chk("t1_done_state", {30'd0, state}, 32'd3);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_cpu_en_off", {31'd0, cpu_en}, 32'd0);
        chk("t1_hr", {30'd0, halt_reason}, 32'd1);
        chk("t1_cc", cycle_count, 32'd7);
        chk("t1_lim_state", {30'd0, l_state}, 32'd3);
        chk("t1_lim_hr", {30'd0, l_halt_reason}, 32'd2);
        chk("t1_lim_cc", l_cycle_count, 32'd5);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk("t1_ack_idle", {30'd0, state}, 32'd0);

        // ---------------- test 2: toggled ld_valid, 3 words ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ld_valid = (k % 2 == 1);
            ld_data  = prog2[k / 2];
            ld_last  = (k == 5);
            #1;
            chk("t2_ready", {31'd0, ld_ready}, 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t2_idle", {30'd0, state}, 32'd0);
        chk("t2_wc", {25'd0, word_count}, 32'd3);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(4 * i);
            #1;
            chk("t2_readback", instr_out, prog2[i]);
        end
        // Word 3 still holds test-1 data but lies beyond word_count.
        pc_in = 32'd12;
        #1;
        chk("t2_beyond_wc", instr_out, NOP);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t2_hr", {30'd0, halt_reason}, 32'd3);
        chk("t2_cc", cycle_count, 32'd1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        // ---------------- test 3: overflow after 64 words ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h10000000 + 32'(i);
            if (i == 63) begin
                #1;
                chk("t3_ready_63", {31'd0, ld_ready}, 32'd1);
                chk("t3_ovf_pre", {31'd0, overflow}, 32'd0);
            end
            tick();
        end
        chk("t3_idle", {30'd0, state}, 32'd0);
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        chk("t3_wc", {25'd0, word_count}, 32'd64);
        ld_data = 32'hDEADBEEF;
        #1;
        chk("t3_ready_65", {31'd0, ld_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        chk("t3_wc_65", {25'd0, word_count}, 32'd64);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        pc_in = 32'd252;
        #1;
        chk("t3_last_word", instr_out, 32'h1000003F);
        pc_in = 32'd0;
        #1;
        chk("t3_first_word", instr_out, 32'h10000000);
        pc_in = 32'd256;
        #1;
        chk("t3_out_of_range", instr_out, NOP);
        pc_in = 32'd2;
        #1;
        chk("t3_misaligned", instr_out, NOP);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        // ---------------- test 4: cycle limit (MAX_CYCLES=5 instance) ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h00500093;
        tick();
        ld_data  = 32'h00108093;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t4_wc", {25'd0, l_word_count}, 32'd2);
        chk("t4_ovf_cleared", {31'd0, l_overflow}, 32'd0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'(4 * i);
            #1;
            chk("t4_state_run", {30'd0, l_state}, 32'd2);
            chk($sformatf("t4_instr_pc%0d", 4 * i), l_instr_out,
                (i == 0) ? 32'h00500093 : ((i == 1) ? 32'h00108093 : NOP));
            tick();
        end
        chk("t4_lim_done", {30'd0, l_state}, 32'd3);
        chk("t4_lim_hr", {30'd0, l_halt_reason}, 32'd2);
        chk("t4_lim_cc", l_cycle_count, 32'd5);
        chk("t4_unlim_run", {30'd0, state}, 32'd2);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t4_unlim_hr", {30'd0, halt_reason}, 32'd3);
        chk("t4_unlim_cc", cycle_count, 32'd6);
        chk("t4_lim_hr_hold", {30'd0, l_halt_reason}, 32'd2);
        chk("t4_lim_cc_hold", l_cycle_count, 32'd5);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("t4_run_ignored", {30'd0, state}, 32'd3);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        // ---------------- test 5: halt_req together with EBREAK ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = EBRK;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        pc_in = 32'd0;
        #1;
        chk("t5_ebreak_fetch", instr_out, EBRK);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t5_hr", {30'd0, halt_reason}, 32'd3);
        chk("t5_cc", cycle_count, 32'd1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk("t5_ack_idle", {30'd0, state}, 32'd0);
        chk("t5_done_low", {31'd0, done}, 32'd0);

        // ---------------- test 6: priority, reset mid-load, NOP run ----------------
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        chk("t6_load_wins", {30'd0, state}, 32'd1);
        ld_valid = 1'b1;
        ld_data  = 32'hCAFE0001;
        tick();
        ld_data  = 32'hCAFE0002;
        tick();
        ld_valid = 1'b0;
        chk("t6_wc_2", {25'd0, word_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", {30'd0, state}, 32'd0);
        chk("t6_rst_wc", {25'd0, word_count}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(4 * i);
            halt_req = (i == 3);
            #1;
            chk("t6_nop_fetch", instr_out, NOP);
            tick();
        end
        halt_req = 1'b0;
        chk("t6_done", {30'd0, state}, 32'd3);
        chk("t6_cc", cycle_count, 32'd4);
        chk("t6_hr", {30'd0, halt_reason}, 32'd3);
        chk("t6_lim_cc", l_cycle_count, 32'd4);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_imem_ctrl.md
Name: riscv_imem_ctrl

Overview:
Instruction-memory controller and run sequencer for the single-cycle riscv_processor.
- Owns a DEPTH x 32 instruction store.
- Loads the store from a host valid/ready stream.
- Drives the processor's Instruction input from PC_out.
- Gates execution with cpu_en and stops the run on EBREAK, a cycle limit or a host halt.

Parameters:
DEPTH, 64, number of 32-bit instruction words.
ADDR_W, 6, log2(DEPTH).
MAX_CYCLES, 0, RUN cycle limit; 0 means unlimited.
NOP_WORD, 32'h00000013, word fetched when no valid instruction is available (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_start  in  1  pulse: begin a program load.
run_start  in  1  pulse: begin execution of the stored program.
halt_req  in  1  host stop request.
done_ack  in  1  acknowledges completion; returns the block to IDLE.
ld_valid  in  1  host load word valid.
ld_data  in  32  host load word.
ld_last  in  1  marks the final load word.
ld_ready  out  1  controller accepts a load word.
pc_in  in  32  processor PC_out.
instr_out  out  32  to processor Instruction.
cpu_en  out  1  processor advance enable.
state  out  2  0=IDLE, 1=LOAD, 2=RUN, 3=DONE.
word_count  out  ADDR_W+1  number of valid words loaded.
cycle_count  out  32  RUN cycles elapsed.
done  out  1  high in DONE.
overflow  out  1  sticky flag: load exceeded DEPTH.
halt_reason  out  2  0=none, 1=EBREAK, 2=cycle limit, 3=host halt.

Behaviour:
- Reset (async, rst_n=0) sets: state=IDLE, word_count=0, cycle_count=0, overflow=0, halt_reason=0. Memory contents are not cleared. A reset during LOAD or RUN aborts that operation immediately.
- Combinational outputs:
  - ld_ready = (state==LOAD).
  - cpu_en = (state==RUN).
  - done = (state==DONE).
- instr_out (combinational). It equals mem[pc_in[ADDR_W+1:2]] only when all of these hold:
  - state==RUN;
  - pc_in[1:0]==0;
  - pc_in < 4*DEPTH;
  - index < word_count.
  Otherwise instr_out = NOP_WORD.
- IDLE:
  - load_start -> LOAD; clears word_count and overflow.
  - run_start (with load_start=0) -> RUN; clears cycle_count and halt_reason.
  - If both are asserted, load_start wins.
- LOAD:
  - Transfer occurs when ld_valid && ld_ready: mem[word_count] <= ld_data, and word_count increments.
  - A transfer with ld_last=1 -> IDLE.
  - If the DEPTH-th word is accepted without ld_last: overflow <= 1, -> IDLE. Further ld_valid is ignored (ld_ready=0).
  - load_start and run_start are ignored during LOAD.
- RUN (one edge per processor instruction):
  - cycle_count increments each RUN cycle and saturates at 32'hFFFFFFFF.
  - Exit conditions evaluated at each edge, in priority order:
    1. halt_req -> DONE, halt_reason=3.
    2. instr_out==32'h00100073 (EBREAK) -> DONE, halt_reason=1. The EBREAK cycle is counted.
    3. MAX_CYCLES!=0 and cycle_count+1==MAX_CYCLES -> DONE, halt_reason=2.
  - Out-of-range fetches return NOP and do not halt.
- DONE:
  - cpu_en=0; cycle_count and halt_reason hold.
  - done_ack -> IDLE.
  - load_start and run_start are ignored until acknowledged.
- A run with word_count=0 executes NOPs until halt_req or the cycle limit.

Test Plan:
1. Load 0xABCDE2B7, 0xBE51C337, 0x190323B7, 0x12328293, 0x7A530313, 0x90338393, 0x00100073 (ld_last on the 7th word), then run_start -> word_count=7; instr_out follows pc 0,4,...,24; DONE after 7 RUN cycles; halt_reason=1; cycle_count=7; processor x5=0xABCDE123, x7=0x19031903.
2. Load 3 words with ld_valid toggling every other cycle -> exactly 3 writes; ld_ready=1 throughout LOAD; returns to IDLE on the 3rd word.
3. Stream 65 words with no ld_last -> 64 accepted, overflow=1, state=IDLE; the 65th word is not accepted.
4. MAX_CYCLES=5, program with no EBREAK -> DONE after 5 cycles, halt_reason=2; fetches beyond word_count return 0x00000013.
5. halt_req asserted on the same cycle EBREAK is fetched -> halt_reason=3; done_ack -> IDLE.
6. rst_n pulled low mid-LOAD after 2 words -> state=IDLE, word_count=0 immediately; a subsequent run_start with halt_req at cycle 4 fetches only NOPs, cycle_count=4.
